// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: fetch/decode pipeline register of the five-stage MIPS core.
// Captures the fetched PC, instruction, fetch exception and delay-slot flag,
// with stall (hold), eret flush (bubble) and exception redirect (bubble at
// the handler PC). Every output is driven straight from a register.
// Optional macro FD_PERF_CNT_EN adds the stall/kill performance counters;
// without it both counter ports read as zero.
module fd_pipe_reg #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        req,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_inst,
    input  logic        F_AdEL,
    input  logic        F_bd,
    output logic [31:0] D_pc,
    output logic [31:0] D_inst,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] kill_cnt
);

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [4:0]  exccode_q;
    logic        bd_q;
    logic        valid_q;

    // D-stage state: reset > redirect > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (req) begin
            pc_q      <= HANDLER_PC;
            inst_q    <= 32'h0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            // Bubble keeps the fetched PC so the pipeline still has a sane PC
            pc_q      <= F_pc;
            inst_q    <= 32'h0;
            exccode_q <= 5'd0;
            bd_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else if (en) begin
            pc_q      <= F_pc;
            inst_q    <= F_AdEL ? 32'h0 : F_inst;
            exccode_q <= F_AdEL ? EXC_ADEL : 5'd0;
            bd_q      <= F_bd;
            valid_q   <= 1'b1;
        end
    end

    assign D_pc      = pc_q;
    assign D_inst    = inst_q;
    assign D_exccode = exccode_q;
    assign D_bd      = bd_q;
    assign D_valid   = valid_q;

`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] kill_cnt_q;

    // A cycle is either a kill (req/flush) or a stall, never both
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'h0;
            kill_cnt_q  <= 32'h0;
        end else if (req || flush) begin
            kill_cnt_q  <= kill_cnt_q + 32'd1;
        end else if (!en) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign kill_cnt  = kill_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign kill_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: directed walk through the basic
// scenarios followed by randomized traffic against a behavioural model.
module tb_fd_pipe_reg;

`ifdef FD_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, en, flush, req, F_AdEL, F_bd;
    logic [31:0] F_pc, F_inst;
    logic [31:0] D_pc, D_inst, stall_cnt, kill_cnt;
    logic [4:0]  D_exccode;
    logic        D_bd, D_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;
    logic [31:0] m_stall, m_kill;

    fd_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .req       (req),
        .F_pc      (F_pc),
        .F_inst    (F_inst),
        .F_AdEL    (F_AdEL),
        .F_bd      (F_bd),
        .D_pc      (D_pc),
        .D_inst    (D_inst),
        .D_exccode (D_exccode),
        .D_bd      (D_bd),
        .D_valid   (D_valid),
        .stall_cnt (stall_cnt),
        .kill_cnt  (kill_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic q,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic adel, input logic bd);
        reset = r; en = e; flush = f; req = q;
        F_pc = pc; F_inst = inst; F_AdEL = adel; F_bd = bd;
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, compare.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0000_3000; m_inst = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            m_stall = 0; m_kill = 0;
        end else begin
            if (req || flush) m_kill = m_kill + 1;
            else if (!en)     m_stall = m_stall + 1;
            if (req) begin
                m_pc = 32'h0000_4180; m_inst = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            end else if (flush) begin
                m_pc = F_pc; m_inst = 0; m_exc = 0; m_bd = 0; m_valid = 0;
            end else if (en) begin
                m_pc = F_pc;
                m_inst = F_AdEL ? 32'h0 : F_inst;
                m_exc = F_AdEL ? 5'd4 : 5'd0;
                m_bd = F_bd;
                m_valid = 1'b1;
            end
        end
        #1;
        check("D_pc", D_pc, m_pc);
        check("D_inst", D_inst, m_inst);
        check("D_exccode", {27'h0, D_exccode}, {27'h0, m_exc});
        check("D_bd", {31'h0, D_bd}, {31'h0, m_bd});
        check("D_valid", {31'h0, D_valid}, {31'h0, m_valid});
        check("stall_cnt", stall_cnt, Perf ? m_stall : 32'h0);
        check("kill_cnt", kill_cnt, Perf ? m_kill : 32'h0);
    endtask

    initial begin
        m_pc = 0; m_inst = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_stall = 0; m_kill = 0;
        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        step();
        check("rst_pc", D_pc, 32'h0000_3000);
        check("rst_valid", {31'h0, D_valid}, 32'h0);

        // Normal load
        drive(0, 1, 0, 0, 32'h3000, 32'h3C01_1234, 0, 0);
        step();
        check("ld_inst", D_inst, 32'h3C01_1234);
        check("ld_valid", {31'h0, D_valid}, 32'h1);

        // Fetch address error: instruction forced to zero, ExcCode 4
        drive(0, 1, 0, 0, 32'h3001, 32'hFFFF_FFFF, 1, 0);
        step();
        check("adel_inst", D_inst, 32'h0);
        check("adel_exc", {27'h0, D_exccode}, 32'd4);

        // Load then stall three cycles with F changing
        drive(0, 1, 0, 0, 32'h3004, 32'h2402_0005, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, $urandom, $urandom, 1'($urandom), 1'($urandom));
            step();
            check("stall_pc", D_pc, 32'h3004);
            check("stall_inst", D_inst, 32'h2402_0005);
        end
        check("stall3", stall_cnt, Perf ? 32'd3 : 32'd0);

        // Redirect beats a simultaneous stall
        drive(0, 0, 0, 1, 32'h3008, 32'h1234_5678, 0, 1);
        step();
        check("req_pc", D_pc, 32'h0000_4180);
        check("req_bd", {31'h0, D_bd}, 32'h0);
        check("req_kill", kill_cnt, Perf ? 32'd1 : 32'd0);

        // Flush keeps F_pc, then a delay-slot load
        drive(0, 1, 1, 0, 32'h3010, 32'h1111_1111, 0, 0);
        step();
        check("flush_pc", D_pc, 32'h3010);
        check("flush_valid", {31'h0, D_valid}, 32'h0);
        drive(0, 1, 0, 0, 32'h3014, 32'h0000_0000, 0, 1);
        step();
        check("bd_load", {31'h0, D_bd}, 32'h1);

        // Reset during a stall with a valid instruction held
        drive(0, 0, 0, 0, 32'h3018, 32'h0, 0, 0);
        step();
        drive(1, 0, 0, 0, 32'h3018, 32'h0, 0, 0);
        step();
        check("rst2_pc", D_pc, 32'h0000_3000);
        check("rst2_valid", {31'h0, D_valid}, 32'h0);
        check("rst2_stall", stall_cnt, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom, $urandom,
                  ($urandom_range(0, 7) == 0),
                  1'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_pipe_reg.md
# fd_pipe_reg

Fetch/decode pipeline register sitting directly downstream of the instruction fetch unit in the five-stage MIPS core. It captures the fetched PC, instruction word, fetch-stage exception and branch-delay flag each cycle, and presents them to the decode stage. It implements stall (hold), eret flush (bubble) and interrupt/exception redirect (bubble at the handler address), so that precise-exception state (EPC, BD) reaches CP0 correctly.

## Interface
Parameters:
- `HANDLER_PC`, 32'h0000_4180, PC loaded into the D stage on an exception/interrupt redirect.
- `RESET_PC`, 32'h0000_3000, D-stage PC after reset.
- `EXC_ADEL`, 5'd4, ExcCode assigned to a fetch address error.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  load enable; 0 = stall, hold all D state.
- `flush`  in  1  eret flush; insert bubble.
- `req`  in  1  exception/interrupt redirect from CP0; insert bubble at handler.
- `F_pc`  in  32  PC of the fetched instruction.
- `F_inst`  in  32  fetched instruction word (already 0 when AdEL).
- `F_AdEL`  in  1  fetch address error.
- `F_bd`  in  1  fetched instruction sits in a branch delay slot.
- `D_pc`  out  32  decode-stage PC.
- `D_inst`  out  32  decode-stage instruction.
- `D_exccode`  out  5  pending ExcCode carried to later stages; 0 = none.
- `D_bd`  out  1  decode instruction is in a delay slot.
- `D_valid`  out  1  1 = real instruction, 0 = bubble.
- `stall_cnt`  out  32  stall cycles (only with FD_PERF_CNT_EN).
- `kill_cnt`  out  32  bubbles inserted by flush/req (only with FD_PERF_CNT_EN).

## Operation
- All state updates on rising `clk`; all outputs driven directly from registers (no combinational path input→output).
- Update priority per cycle: `reset` > `req` > `flush` > `!en` > load.
- reset: D_pc=RESET_PC, D_inst=0, D_exccode=0, D_bd=0, D_valid=0; counters=0.
- req: D_pc=HANDLER_PC, D_inst=0, D_exccode=0, D_bd=0, D_valid=0. Overrides a simultaneous stall (en=0) and flush.
- flush (req=0): D_pc=F_pc, D_inst=0, D_exccode=0, D_bd=0, D_valid=0. Overrides stall. Keeping F_pc preserves a meaningful macroscopic PC for the bubble.
- stall (en=0, no req/flush): every D register holds its value, D_valid included.
- load: D_pc=F_pc, D_inst=F_inst, D_bd=F_bd, D_valid=1, D_exccode=F_AdEL ? EXC_ADEL : 0. When F_AdEL=1, D_inst is forced to 0 regardless of F_inst.
- D_exccode is never set by any other source in this block; decode-stage exceptions (RI, syscall) merge downstream.

## Timing
- Latency: one cycle F→D; values presented in cycle N appear on D_* after edge N+1.
- Stall of k cycles: D_* constant for k edges, then loads the F value present on the first edge with en=1.
- req and flush are single-cycle pulses from the controller; if held high, the bubble is re-inserted every cycle.
- Reset mid-operation discards any pending stall/redirect; first edge after reset deasserts yields normal load.
- Counters: stall_cnt +1 on each edge with en=0, req=0, flush=0, reset=0; kill_cnt +1 on each edge with req|flush and reset=0. Both are 32-bit, wrap from 32'hFFFF_FFFF to 0, and never increment in the same cycle for the same event.

## Configuration
- `FD_PERF_CNT_EN`: defined → stall_cnt/kill_cnt registers and ports exist and count as above. Undefined → counters are not instantiated and both ports are tied to 32'h0; all other behaviour is identical.

## Test plan
- Reset, then load F_pc=0x3000, F_inst=0x3C011234, en=1 → next edge D_pc=0x3000, D_inst=0x3C011234, D_valid=1, D_exccode=0.
- Load F_pc=0x3001, F_AdEL=1, F_inst=0xFFFFFFFF → D_inst=0, D_exccode=4, D_pc=0x3001, D_valid=1.
- Load 0x3004 / 0x24020005, then en=0 for 3 cycles with F changing → D_* unchanged for 3 edges; stall_cnt=3.
- req=1 together with en=0 and F_bd=1 → D_pc=0x4180, D_inst=0, D_bd=0, D_valid=0; kill_cnt +1.
- flush=1 with F_pc=0x3010 → D_pc=0x3010, D_inst=0, D_valid=0; next edge with en=1 loads normally with F_bd=1 → D_bd=1.
- reset asserted during a stall with D_valid=1 → D_pc=0x3000, D_valid=0, counters=0.
